// File: rtl/div3_pkg.sv
`default_nettype none
// ============================================================================
// div3_pkg : shared state encoding and constants for the div-by-3 word feeder
// Revision : 1.0 - initial release
// ============================================================================
package div3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bit MSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div3_word_top.sv
`default_nettype none
// ============================================================================
// div3_word_top : feeder and three_mult detector wired back-to-back
// Revision      : 1.0 - initial release
// ============================================================================
module div3_word_top #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [WIDTH-1:0] result_word,
  output logic             result_div3,
  output logic             result_valid,
  input  logic             result_ready
);

  logic w_det_bit;
  logic w_det_clr;
  logic w_det_out;

  div3_word_feeder #(
    .WIDTH (WIDTH)
  ) u_feeder (
    .clk          (clk),
    .reset        (reset),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .det_bit      (w_det_bit),
    .det_clr      (w_det_clr),
    .det_out      (w_det_out),
    .result_word  (result_word),
    .result_div3  (result_div3),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  three_mult u_det (
    .clk   (clk),
    .reset (w_det_clr),
    .din   (w_det_bit),
    .dout  (w_det_out)
  );

endmodule
`default_nettype wire

// File: rtl/piso_shreg.sv
`default_nettype none
// ============================================================================
// piso_shreg : parallel-load, shift-left register with a serial tap
// Revision   : 1.0 - initial release
// ============================================================================
module piso_shreg
  import div3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             tap
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign tap = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];

endmodule
`default_nettype wire

// File: rtl/three_mult.sv
`default_nettype none
// ============================================================================
// three_mult : serial MSB-first divisible-by-3 detector, Mealy output
// Revision   : 1.0 - initial release
// ============================================================================
module three_mult (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [1:0] r_rem;
  logic [1:0] w_rem;

  // Remainder of the prefix after appending din: (2*rem + din) mod 3.
  always_comb begin
    w_rem = 2'd0;
    case (r_rem)
      2'd0:    w_rem = din ? 2'd1 : 2'd0;
      2'd1:    w_rem = din ? 2'd0 : 2'd2;
      2'd2:    w_rem = din ? 2'd2 : 2'd1;
      default: w_rem = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= 2'd0;
    end else begin
      r_rem <= w_rem;
    end
  end

  assign dout = (w_rem == 2'd0);

endmodule
`default_nettype wire

// File: rtl/div3_word_feeder.sv
`default_nettype none
// ============================================================================
// div3_word_feeder : serialises a word into the three_mult detector and
//                    returns the word with its divisible-by-3 verdict
// Revision         : 1.0 - initial release
// ============================================================================
module div3_word_feeder
  import div3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             det_bit,
  output logic             det_clr,
  input  logic             det_out,
  output logic [WIDTH-1:0] result_word,
  output logic             result_div3,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_div3;
  logic             w_load;
  logic             w_shift;
  logic             w_tap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: begin
        if (word_valid) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == c_last) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        w_next = DONE;
      end
      DONE: begin
        if (result_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_div3 <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt  <= '0;
        r_word <= word_in;
      end else if (w_shift) begin
        r_cnt  <= r_cnt + 1'b1;
      end
      // The detector saw every bit by now and gets a 0 this cycle.
      if (r_state == WAIT) begin
        r_div3 <= det_out;
      end
    end
  end

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .d     (word_in),
    .tap   (w_tap)
  );

  assign word_ready   = (r_state == IDLE);
  assign det_clr      = (r_state == IDLE) || (r_state == DONE);
  assign det_bit      = (r_state == SHIFT) && w_tap;
  assign result_valid = (r_state == DONE);
  assign result_word  = r_word;
  assign result_div3  = r_div3;

endmodule
`default_nettype wire
